// File: rtl/bp_update_ctrl_pkg.sv
// Shared types and the 2-bit saturating counter rule for the branch prediction table.
package bp_update_ctrl_pkg;

  localparam int BP_ENTRIES = 1024;

  typedef logic [9:0] bp_idx_t;
  typedef logic [1:0] bp_ctr_t;

  localparam bp_ctr_t BP_INIT = 2'b10;

  typedef enum logic {ST_INIT, ST_RUN} bp_state_t;

  function automatic bp_ctr_t bp_sat_update(bp_ctr_t ctr, logic taken);
    bp_ctr_t res;
    if (taken) res = (ctr == 2'd3) ? 2'd3 : ctr + 2'd1;
    else       res = (ctr == 2'd0) ? 2'd0 : ctr - 2'd1;
    return res;
  endfunction

endpackage

// File: rtl/bp_fb_fifo.sv
// Synchronous feedback FIFO with registered full/empty flags and a flush input.
module bp_fb_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          do_push, do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (flush)                  count_nxt = '0;
    else if (do_push && !do_pop) count_nxt = count + 1'b1;
    else if (do_pop && !do_push) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bp_update_ctrl.sv
// Update controller for the 2-bit branch prediction table: feedback FIFO,
// forwarded read-modify-write pipeline, and full-table initialisation.
module bp_update_ctrl
  import bp_update_ctrl_pkg::*;
#(
  parameter int         IDX_W      = 10,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] INIT_VAL   = BP_INIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fb_valid,
  output logic             fb_ready,
  input  logic [63:0]      fb_pc,
  input  logic             fb_taken,
  input  logic             flush_req,
  output logic             busy,
  output logic             pred_enable,
  output logic [IDX_W-1:0] tbl_rd_idx,
  input  logic [1:0]       tbl_rd_data,
  output logic             tbl_we,
  output logic [IDX_W-1:0] tbl_wr_idx,
  output logic [1:0]       tbl_wr_data
);

  localparam int ENT_W = IDX_W + 1;

  bp_state_t        state;
  logic [IDX_W-1:0] init_cnt;

  logic             fifo_full, fifo_empty, push;
  logic [ENT_W-1:0] head;
  logic             pc_unused;

  logic             pop_p0, taken_p0;
  logic [IDX_W-1:0] idx_p0;
  bp_ctr_t          operand_p0;

  logic             vld_p1;
  logic [IDX_W-1:0] idx_p1;
  bp_ctr_t          ctr_p1;

  assign pc_unused   = ^{fb_pc[63:IDX_W+2], fb_pc[1:0]};
  assign busy        = (state == ST_INIT);
  assign pred_enable = (state == ST_RUN);
  assign fb_ready    = (state == ST_RUN) && !fifo_full && !flush_req;
  assign push        = fb_valid && fb_ready;

  bp_fb_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_req),
    .push  (push),
    .din   ({fb_pc[IDX_W+1:2], fb_taken}),
    .pop   (pop_p0),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Stage 0: pop head, read table, forward the in-flight write on an index match
  assign idx_p0     = head[ENT_W-1:1];
  assign taken_p0   = head[0];
  assign pop_p0     = (state == ST_RUN) && !fifo_empty && !flush_req;
  assign tbl_rd_idx = pop_p0 ? idx_p0 : '0;
  assign operand_p0 = (vld_p1 && (idx_p1 == idx_p0)) ? ctr_p1 : tbl_rd_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      vld_p1   <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          vld_p1 <= 1'b0;
          if (flush_req) begin
            init_cnt <= '0;
          end else begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == '1) state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (flush_req) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            vld_p1   <= 1'b0;
          end else begin
            vld_p1 <= pop_p0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Stage 1: registered index and updated counter, written to the table
  always_ff @(posedge clk) begin
    if (pop_p0) begin
      idx_p1 <= idx_p0;
      ctr_p1 <= bp_sat_update(operand_p0, taken_p0);
    end
  end

  // Write port is held idle while reset is asserted even though state reads INIT
  always_comb begin
    tbl_we      = 1'b0;
    tbl_wr_idx  = '0;
    tbl_wr_data = '0;
    if (rst) begin
      if (state == ST_INIT) begin
        tbl_we      = 1'b1;
        tbl_wr_idx  = init_cnt;
        tbl_wr_data = INIT_VAL;
      end else if (vld_p1 && !flush_req) begin
        tbl_we      = 1'b1;
        tbl_wr_idx  = idx_p1;
        tbl_wr_data = ctr_p1;
      end
    end
  end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Randomised and directed bench for bp_update_ctrl against a schedule-based table model.
module tb_bp_update_ctrl;

  logic        clk;
  logic        rst;
  logic        fb_valid;
  logic        fb_ready;
  logic [63:0] fb_pc;
  logic        fb_taken;
  logic        flush_req;
  logic        busy;
  logic        pred_enable;
  logic [9:0]  tbl_rd_idx;
  logic [1:0]  tbl_rd_data;
  logic        tbl_we;
  logic [9:0]  tbl_wr_idx;
  logic [1:0]  tbl_wr_data;

  bp_update_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .fb_valid    (fb_valid),
    .fb_ready    (fb_ready),
    .fb_pc       (fb_pc),
    .fb_taken    (fb_taken),
    .flush_req   (flush_req),
    .busy        (busy),
    .pred_enable (pred_enable),
    .tbl_rd_idx  (tbl_rd_idx),
    .tbl_rd_data (tbl_rd_data),
    .tbl_we      (tbl_we),
    .tbl_wr_idx  (tbl_wr_idx),
    .tbl_wr_data (tbl_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table memory: same-cycle read, write on the clock edge
  logic [1:0] mem [1024];
  assign tbl_rd_data = mem[tbl_rd_idx];
  always @(posedge clk) if (tbl_we) mem[tbl_wr_idx] <= tbl_wr_data;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: committed table values plus a schedule of accepted
  // updates, each due two cycles after acceptance, applied in order.
  typedef struct {
    int idx;
    bit tk;
    int due;
  } upd_t;

  upd_t sched[$];
  int   mtbl [1024];
  bit   m_init;
  int   m_idx;
  int   cyc;

  function automatic int sat(int c, bit tk);
    if (tk) return (c + 1 > 3) ? 3 : c + 1;
    return (c - 1 < 0) ? 0 : c - 1;
  endfunction

  task automatic model_enter_init();
    sched.delete();
    m_init = 1'b1;
    m_idx  = 0;
    for (int i = 0; i < 1024; i++) mtbl[i] = 2;
  endtask

  // Called at the falling edge: drive inputs, check, advance one cycle
  task automatic step(input bit v, input logic [63:0] pc, input bit tk, input bit fl);
    bit exp_ready, exp_we;
    int exp_idx, exp_dat;
    fb_valid  = v;
    fb_pc     = pc;
    fb_taken  = tk;
    flush_req = fl;
    #1;
    exp_ready = !m_init && !fl;
    chk("busy", 32'(busy), 32'(m_init));
    chk("pred_enable", 32'(pred_enable), 32'(!m_init));
    chk("fb_ready", 32'(fb_ready), 32'(exp_ready));
    exp_we  = 1'b0;
    exp_idx = 0;
    exp_dat = 0;
    if (m_init) begin
      exp_we  = 1'b1;
      exp_idx = m_idx;
      exp_dat = 2;
    end else if (sched.size() > 0 && sched[0].due == cyc) begin
      if (!fl) begin
        exp_we  = 1'b1;
        exp_idx = sched[0].idx;
        exp_dat = sat(mtbl[sched[0].idx], sched[0].tk);
        mtbl[exp_idx] = exp_dat;
      end
      void'(sched.pop_front());
    end
    chk("tbl_we", 32'(tbl_we), 32'(exp_we));
    if (exp_we) begin
      chk("tbl_wr_idx", 32'(tbl_wr_idx), 32'(exp_idx));
      chk("tbl_wr_data", 32'(tbl_wr_data), 32'(exp_dat));
    end
    if (v && exp_ready) sched.push_back('{idx: int'(pc[11:2]), tk: tk, due: cyc + 2});
    if (m_init) begin
      if (fl) m_idx = 0;
      else if (m_idx == 1023) m_init = 1'b0;
      else m_idx++;
    end else if (fl) begin
      model_enter_init();
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 64'h0, 1'b0, 1'b0);
  endtask

  task automatic finish_init();
    while (m_init) step(1'b0, 64'h0, 1'b0, 1'b0);
  endtask

  // Assert reset at a falling edge, check the reset outputs, release next falling edge
  task automatic do_reset();
    fb_valid  = 1'b0;
    fb_pc     = '0;
    fb_taken  = 1'b0;
    flush_req = 1'b0;
    rst       = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_pred_enable", 32'(pred_enable), 32'd0);
    chk("rst_fb_ready", 32'(fb_ready), 32'd0);
    chk("rst_tbl_we", 32'(tbl_we), 32'd0);
    chk("rst_wr_idx", 32'(tbl_wr_idx), 32'd0);
    chk("rst_wr_data", 32'(tbl_wr_data), 32'd0);
    chk("rst_rd_idx", 32'(tbl_rd_idx), 32'd0);
    model_enter_init();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [63:0] pc;
    rst       = 1'b0;
    fb_valid  = 1'b0;
    fb_pc     = '0;
    fb_taken  = 1'b0;
    flush_req = 1'b0;
    cyc       = 0;
    @(negedge clk);
    do_reset();
    finish_init();
    chk("post_init_ready", 32'(fb_ready), 32'd1);

    // Single taken update on idx 1, then repeat: saturates at 3
    step(1'b1, 64'h1004, 1'b1, 1'b0);
    idle(3);
    chk("mem1_after_taken", 32'(mem[1]), 32'd3);
    step(1'b1, 64'h1004, 1'b1, 1'b0);
    idle(3);
    chk("mem1_saturated", 32'(mem[1]), 32'd3);

    // Back-to-back not-taken on idx 2 exercises forwarding
    for (int i = 0; i < 3; i++) step(1'b1, 64'h2008, 1'b0, 1'b0);
    idle(3);
    chk("mem2_after_nt3", 32'(mem[2]), 32'd0);

    // Five offers in consecutive cycles
    for (int i = 0; i < 5; i++) step(1'b1, 64'h10 + 64'(4 * (i % 3)), i[0], 1'b0);
    idle(4);

    // Flush with entries in flight, then a full reinitialisation
    for (int i = 0; i < 3; i++) step(1'b1, 64'h3000 + 64'(4 * i), 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b1);
    finish_init();

    // Flush during INIT restarts the index sweep
    idle(1);
    step(1'b0, 64'h0, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) step(1'b0, 64'h0, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b1);
    finish_init();

    // Reset in the middle of INIT
    step(1'b0, 64'h0, 1'b0, 1'b1);
    while (m_idx != 500) step(1'b0, 64'h0, 1'b0, 1'b0);
    do_reset();
    finish_init();

    // Randomised traffic on a small index set with rare flushes
    for (int i = 0; i < 400; i++) begin
      pc = {$urandom, $urandom};
      pc[11:2] = 10'($urandom_range(0, 7));
      step(1'($urandom_range(0, 3) != 0), pc, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 199) == 0));
    end
    finish_init();
    idle(4);
    for (int i = 0; i < 8; i++) chk("final_mem", 32'(mem[i]), 32'(mtbl[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
